// File: rtl/rank_scanner.sv
// rank_scanner: walks the external 8:1 mux across the eight squares of one
// chess-board rank, assembles an occupancy byte, flags squares that changed
// since the last published scan, and offers the result on valid/ready.
module rank_scanner #(
  parameter int SETTLE = 1  // cycles the select is held before each sample (1..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_out,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       busy,
  output logic [7:0] occ,
  output logic [7:0] changed,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_HOLD
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] shadow;
  logic [7:0] prev;
  logic [7:0] scan_word;

  // Full rank as it stands on the final sample edge: square 7 comes straight
  // from the mux, squares 0..6 from the shadow register.
  assign scan_word = {mux_out, shadow[6:0]};

  // State register; reset wins over everything, including a scan in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == LAST_CNT) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (idx == 3'd7) ? S_HOLD : S_SETTLE;
      S_HOLD:   if (valid && ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: square index, settle counter, shadow, published result.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadow and prev are cleared too, so an aborted scan can never
      // leak stale squares and the next change mask is relative to zero.
      idx     <= 3'd0;
      cnt     <= 4'd0;
      shadow  <= 8'h00;
      prev    <= 8'h00;
      occ     <= 8'h00;
      changed <= 8'h00;
      valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx <= 3'd0;
            cnt <= 4'd0;
          end
        end
        S_SETTLE: cnt <= cnt + 4'd1;
        S_SAMPLE: begin
          shadow[idx] <= mux_out;
          cnt         <= 4'd0;
          if (idx == 3'd7) begin
            occ     <= scan_word;
            changed <= scan_word ^ prev;
            prev    <= scan_word;
            valid   <= 1'b1;
            idx     <= 3'd0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_HOLD: if (valid && ready) valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Busy and mux select: the select only follows idx while a scan runs.
  assign busy           = (state == S_SETTLE) || (state == S_SAMPLE);
  assign {sel2, sel1, sel0} = busy ? idx : 3'd0;

endmodule

// File: tb/tb_rank_scanner.sv
// Directed bench for rank_scanner: one SETTLE=1 instance for the main
// scenarios and one SETTLE=3 instance for the long-settle case.
module tb_rank_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic       mux_out;
  logic       sel0, sel1, sel2, busy, valid;
  logic [7:0] occ, changed;
  logic [7:0] pattern = 8'h00;
  logic [2:0] sel_now;

  logic       start3 = 1'b0;
  logic       mux_out3 = 1'b0;
  logic       sel0_3, sel1_3, sel2_3, busy3, valid3;
  logic [7:0] occ3, changed3;
  logic [2:0] sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sel_now = {sel2, sel1, sel0};
  assign sel3    = {sel2_3, sel1_3, sel0_3};
  assign mux_out = pattern[sel_now];

  rank_scanner #(.SETTLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mux_out(mux_out),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .busy(busy),
    .occ(occ), .changed(changed), .valid(valid), .ready(ready)
  );

  rank_scanner #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .mux_out(mux_out3),
    .sel0(sel0_3), .sel1(sel1_3), .sel2(sel2_3), .busy(busy3),
    .occ(occ3), .changed(changed3), .valid(valid3), .ready(1'b1)
  );

  // Pulse start from IDLE and wait for valid; reports latency in edges after
  // the accepting edge and how many cycles the select deviated from n/2.
  task automatic run_scan(input logic [7:0] pat, output int lat,
                          output logic [7:0] o, output logic [7:0] c,
                          output int sel_err);
    pattern = pat;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    sel_err = 0;
    while (!valid && lat < 200) begin
      if (sel_now !== 3'(lat >> 1)) sel_err++;
      @(negedge clk); lat++;
    end
    o = occ;
    c = changed;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({valid, busy, sel_now, occ, changed} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values got valid=%b busy=%b sel=%0d occ=%h chg=%h want all 0",
               valid, busy, sel_now, occ, changed);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_scan();
    int lat, serr; logic [7:0] o, c;
    ready = 1'b1;
    run_scan(8'hA5, lat, o, c, serr);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL scan1_latency got %0d want 16", lat); end
    checks++;
    if (o !== 8'hA5) begin errors++; $display("FAIL scan1_occ got %h want a5", o); end
    checks++;
    if (c !== 8'hA5) begin errors++; $display("FAIL scan1_changed got %h want a5", c); end
    checks++;
    if (serr !== 0) begin errors++; $display("FAIL scan1_sel_trace got %0d bad cycles want 0", serr); end
    checks++;
    if (busy !== 1'b0 || sel_now !== 3'd0) begin
      errors++; $display("FAIL scan1_hold_outputs got busy=%b sel=%0d want 0/0", busy, sel_now);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL scan1_valid_drop got %b want 0", valid); end
  endtask

  task automatic test_changed_mask();
    int lat, serr; logic [7:0] o, c;
    run_scan(8'hA4, lat, o, c, serr);
    checks++;
    if (o !== 8'hA4) begin errors++; $display("FAIL scan2_occ got %h want a4", o); end
    checks++;
    if (c !== 8'h01) begin errors++; $display("FAIL scan2_changed got %h want 01", c); end
    @(negedge clk);
    run_scan(8'hA4, lat, o, c, serr);
    checks++;
    if (o !== 8'hA4) begin errors++; $display("FAIL scan3_occ got %h want a4", o); end
    checks++;
    if (c !== 8'h00) begin errors++; $display("FAIL scan3_changed got %h want 00", c); end
    @(negedge clk);
  endtask

  task automatic test_hold_backpressure();
    int lat, serr; logic [7:0] o, c;
    ready = 1'b0;
    run_scan(8'h5A, lat, o, c, serr);
    checks++;
    if (o !== 8'h5A || c !== 8'hFE) begin
      errors++; $display("FAIL hold_result got occ=%h chg=%h want 5a/fe", o, c);
    end
    for (int i = 0; i < 20; i++) begin
      start   = (i % 3 == 0);
      pattern = 8'(i * 37);
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || busy !== 1'b0 || occ !== 8'h5A || changed !== 8'hFE) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got valid=%b busy=%b occ=%h chg=%h want 1/0/5a/fe",
                 i, valid, busy, occ, changed);
      end
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL hold_release got valid=%b want 0", valid); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_queued_start got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, serr, guard; logic [7:0] o, c;
    pattern = 8'h3C;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (sel_now !== 3'd4 && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (sel_now !== 3'd4) begin errors++; $display("FAIL abort_reach_idx4 got sel=%0d want 4", sel_now); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({valid, busy, sel_now, occ, changed} !== 21'd0) begin
      errors++;
      $display("FAIL abort_reset_values got valid=%b busy=%b sel=%0d occ=%h chg=%h want all 0",
               valid, busy, sel_now, occ, changed);
    end
    run_scan(8'h3C, lat, o, c, serr);
    checks++;
    if (o !== 8'h3C || c !== 8'h3C) begin
      errors++; $display("FAIL abort_rescan got occ=%h chg=%h want 3c/3c", o, c);
    end
    @(negedge clk);
  endtask

  task automatic test_settle3();
    int k, serr;
    logic [7:0] pat3 = 8'hFF;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    k = 0;
    serr = 0;
    while (!valid3 && k < 200) begin
      mux_out3 = (k % 4 == 3) ? pat3[sel3] : 1'b0;
      if (sel3 !== 3'(k >> 2)) serr++;
      @(negedge clk); k++;
    end
    mux_out3 = 1'b0;
    checks++;
    if (k !== 32) begin errors++; $display("FAIL settle3_latency got %0d want 32", k); end
    checks++;
    if (occ3 !== 8'hFF) begin errors++; $display("FAIL settle3_occ got %h want ff", occ3); end
    checks++;
    if (serr !== 0) begin errors++; $display("FAIL settle3_sel_trace got %0d bad cycles want 0", serr); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int p;
    pattern = 8'h81;
    ready = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 54; n++) begin
      @(negedge clk);
      p = n % 18;
      checks++;
      if (busy !== (p < 16) || valid !== (p == 16)) begin
        errors++;
        $display("FAIL b2b_phase n=%0d got busy=%b valid=%b want %b/%b",
                 n, busy, valid, (p < 16), (p == 16));
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_after got busy=%b valid=%b want 0/0", busy, valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_changed_mask();
    test_hold_backpressure();
    test_reset_abort();
    test_settle3();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
